// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch FSM encoding, IF/ID bundle and default NOP.
// Optional feature macro: FETCH_PERF_CNT_EN (adds fetch/bubble counters).
package pipeline_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pcPlus4;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load enable and flush (flush has priority).
// Used by fetch_stage.
module ifid_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  logic  i_flush,
    input  ifid_t i_d,
    output ifid_t o_q
);

    ifid_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '{inst: NOP_INST, pcPlus4: 32'd0, valid: 1'b0};
        end else if (i_flush) begin
            r_q <= '{inst: NOP_INST, pcPlus4: 32'd0, valid: 1'b0};
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, FETCH/HOLD FSM, one-word skid buffer, IF/ID.
// Define FETCH_PERF_CNT_EN to add fetchCount/bubbleCount outputs.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcWrite,
    input  logic        IFIDWrite,
    input  logic        ifFlush,
    input  logic        jump,
    input  logic [31:0] jumpTarget,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] IFIDInst,
    output logic [31:0] IFIDPcPlus4,
    output logic        IFIDValid,
    output logic        fetchBusy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] bubbleCount
`endif
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_skidInst;
    logic [31:0]  r_skidPc4;

    logic [31:0]  w_pcPlus4;
    logic         w_advance;
    logic         w_load;
    ifid_t        w_d;
    ifid_t        w_q;

    assign w_pcPlus4 = pc_inc(r_pc);
    assign w_advance = IFIDWrite & pcWrite;

    assign imemReq   = (r_state == FETCH);
    assign imemAddr  = r_pc;
    assign fetchBusy = (r_state == FETCH) & ~imemReady;

    // Next IF/ID contents; flush is applied inside ifid_reg
    always_comb begin
        w_load = 1'b0;
        w_d    = '{inst: NOP_INST, pcPlus4: w_pcPlus4, valid: 1'b0};
        unique case (r_state)
            FETCH: begin
                if (imemReady) begin
                    if (w_advance) begin
                        w_load = 1'b1;
                        w_d    = '{inst: imemData, pcPlus4: w_pcPlus4, valid: 1'b1};
                    end
                end else if (IFIDWrite) begin
                    w_load = 1'b1;
                end
            end
            HOLD: begin
                if (w_advance) begin
                    w_load = 1'b1;
                    w_d    = '{inst: r_skidInst, pcPlus4: r_skidPc4, valid: 1'b1};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_skidInst <= 32'd0;
            r_skidPc4  <= 32'd0;
        end else if (ifFlush) begin
            r_state    <= FETCH;
            r_pc       <= jump ? jumpTarget : branchTarget;
            r_skidInst <= 32'd0;
            r_skidPc4  <= 32'd0;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (imemReady) begin
                        if (w_advance) begin
                            r_pc <= w_pcPlus4;
                        end else begin
                            r_skidInst <= imemData;
                            r_skidPc4  <= w_pcPlus4;
                            r_state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_advance) begin
                        r_pc    <= w_pcPlus4;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (ifFlush),
        .i_d     (w_d),
        .o_q     (w_q)
    );

    assign IFIDInst    = w_q.inst;
    assign IFIDPcPlus4 = w_q.pcPlus4;
    assign IFIDValid   = w_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetchCount;
    logic [31:0] r_bubbleCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetchCount  <= 32'd0;
            r_bubbleCount <= 32'd0;
        end else if (ifFlush) begin
            r_bubbleCount <= r_bubbleCount + 32'd1;
        end else if (w_load) begin
            if (w_d.valid) begin
                r_fetchCount <= r_fetchCount + 32'd1;
            end else begin
                r_bubbleCount <= r_bubbleCount + 32'd1;
            end
        end
    end

    assign fetchCount  = r_fetchCount;
    assign bubbleCount = r_bubbleCount;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus random traffic
// checked against a transaction-level model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcWrite, IFIDWrite, ifFlush, jump;
    logic [31:0] jumpTarget, branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] IFIDInst, IFIDPcPlus4;
    logic        IFIDValid, fetchBusy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCount, bubbleCount;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pcWrite      (pcWrite),
        .IFIDWrite    (IFIDWrite),
        .ifFlush      (ifFlush),
        .jump         (jump),
        .jumpTarget   (jumpTarget),
        .branchTarget (branchTarget),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemReady    (imemReady),
        .imemData     (imemData),
        .IFIDInst     (IFIDInst),
        .IFIDPcPlus4  (IFIDPcPlus4),
        .IFIDValid    (IFIDValid),
        .fetchBusy    (fetchBusy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetchCount   (fetchCount),
        .bubbleCount  (bubbleCount)
`endif
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        busy;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: program counter, an optional parked word, IF/ID view
    logic [31:0] m_pc;
    logic [31:0] m_parked[$];
    logic [31:0] m_inst, m_pc4;
    logic        m_valid;
    int unsigned m_fc, m_bc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_parked.delete();
        m_inst  = NOP;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
        m_fc    = 0;
        m_bc    = 0;
    endtask

    task automatic idle();
        pcWrite = 1'b0; IFIDWrite = 1'b0; ifFlush = 1'b0; jump = 1'b0;
        jumpTarget = 32'd0; branchTarget = 32'd0;
        imemReady = 1'b0; imemData = 32'd0;
    endtask

    // One clock of stimulus; expectation pushed for the monitor
    task automatic step(input bit pw, input bit iw, input bit fl,
                        input bit jp, input logic [31:0] jt,
                        input logic [31:0] bt, input bit rdy,
                        input logic [31:0] dat);
        exp_t e;
        bit   go;
        pcWrite = pw; IFIDWrite = iw; ifFlush = fl; jump = jp;
        jumpTarget = jt; branchTarget = bt;
        imemReady = rdy; imemData = dat;
        go     = pw && iw;
        e.req  = (m_parked.size() == 0);
        e.addr = m_pc;
        e.busy = (m_parked.size() == 0) && !rdy;
        if (fl) begin
            m_inst = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
            m_parked.delete();
            m_pc = jp ? jt : bt;
            m_bc++;
        end else if (m_parked.size() != 0) begin
            if (go) begin
                m_inst = m_parked.pop_front();
                m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_fc++;
            end
        end else if (rdy) begin
            if (go) begin
                m_inst = dat; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_fc++;
            end else begin
                m_parked.push_back(dat);
            end
        end else if (iw) begin
            m_inst = NOP; m_pc4 = m_pc + 32'd4; m_valid = 1'b0;
            m_bc++;
        end
        e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok();
        step(1, 1, 0, 0, 0, 0, 1, 32'hA500_0000 ^ m_pc);
    endtask

    task automatic drain();
        idle();
        #2;
    endtask

    // Monitor: combinational outputs before the edge, IF/ID after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q[0];
                chk("imemReq", imemReq, e.req);
                chk("imemAddr", imemAddr, e.addr);
                chk("fetchBusy", fetchBusy, e.busy);
                @(posedge clk);
                #2;
                e = q.pop_front();
                chk("IFIDInst", IFIDInst, e.inst);
                chk("IFIDPcPlus4", IFIDPcPlus4, e.pc4);
                chk("IFIDValid", IFIDValid, e.valid);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst", IFIDInst, NOP);
        chk("rst_pc4", IFIDPcPlus4, 32'd0);
        chk("rst_valid", IFIDValid, 1'b0);
        chk("rst_req", imemReq, 1'b1);
        chk("rst_addr", imemAddr, RST_PC);
        rst = 1'b0;

        // Streaming fetch, then a two-cycle memory wait at PC=8
        fetch_ok();
        fetch_ok();
        step(1, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        step(1, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        fetch_ok();

        // Stall while word returns at PC=12, then release
        step(0, 0, 0, 0, 0, 0, 1, 32'h2002_0005);
        step(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
        step(0, 0, 0, 0, 0, 0, 0, 32'h2222_2222);
        step(1, 1, 0, 0, 0, 0, 0, 32'h3333_3333);
        drain();
        chk("hold_inst", IFIDInst, 32'h2002_0005);
        chk("hold_pc4", IFIDPcPlus4, 32'd16);
        chk("hold_next", imemAddr, 32'd16);

        // Flush during HOLD with jump and branch both present
        step(1, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
        step(1, 1, 1, 1, 32'h40, 32'h80, 0, 32'd0);
        drain();
        chk("flush_valid", IFIDValid, 1'b0);
        chk("flush_addr", imemAddr, 32'h40);
        chk("flush_req", imemReq, 1'b1);

        // Flush drops a word returned in the same cycle
        step(1, 1, 1, 0, 32'h40, 32'h103, 1, 32'h7777_7777);
        drain();
        chk("flush_rdy_inst", IFIDInst, NOP);
        chk("flush_rdy_addr", imemAddr, 32'h103);

        // PC+4 wraps at the top of the address space
        step(1, 1, 1, 0, 0, 32'hFFFF_FFFC, 0, 32'd0);
        fetch_ok();
        drain();
        chk("wrap_pc4", IFIDPcPlus4, 32'd0);
        chk("wrap_addr", imemAddr, 32'd0);

        // Reset during HOLD abandons the parked word
        step(0, 1, 0, 0, 0, 0, 1, 32'h9999_0000);
        drain();
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", IFIDValid, 1'b0);
        chk("mid_rst_req", imemReq, 1'b1);
        chk("mid_rst_addr", imemAddr, RST_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 400; i++) begin
            bit          fl, jp;
            logic [31:0] jt, bt;
            fl = ($urandom_range(0, 11) == 0);
            jp = $urandom_range(0, 1);
            jt = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : $urandom;
            bt = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, fl,
                 jp, jt, bt, $urandom_range(0, 9) < 7, $urandom);
        end
        drain();
        #10;
        chk("queue_empty", q.size(), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("fetchCount", fetchCount, m_fc);
        chk("bubbleCount", bubbleCount, m_bc);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
